// File: rtl/key_device.sv
// ---------------------------------------------------------------------------
// key_device
//   Memory-mapped push-button controller. Raw active-low buttons are
//   synchronized, inverted (1 = pressed) and debounced. Each accepted change
//   of the debounced vector is a "key event". A key event latches the new
//   vector into KDATA, sets ready, and flags overrun if the previous value
//   was never read. An interrupt is raised while ready and ie are both set.
//
// Ports
//   clk      : sole clock, rising edge
//   reset    : asynchronous, active-high reset
//   abus     : CPU byte address
//   we       : CPU store strobe
//   re       : CPU load strobe
//   dbusIn   : CPU store data
//   dbusOut  : CPU load data (combinational, zero when not addressed)
//   KEY      : raw buttons, asynchronous, active-low
//   intr     : interrupt request (ready & ie)
//
// Register map
//   ADDR_KDATA : [KEY_BITS-1:0] debounced pressed vector (RO, read clears ready)
//   ADDR_KCTRL : [8] ie (RW), [1] overrun (write 0 clears), [0] ready (RO)
// ---------------------------------------------------------------------------
module key_device #(
    parameter int               DBITS           = 32,
    parameter int               KEY_BITS        = 4,
    parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(32'hF0000010),
    parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(32'hF0000110),
    parameter int               DEBOUNCE_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    abus,
    input  logic                we,
    input  logic                re,
    input  logic [DBITS-1:0]    dbusIn,
    output logic [DBITS-1:0]    dbusOut,
    input  logic [KEY_BITS-1:0] KEY,
    output logic                intr
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_BITS-1:0] s1;
    logic [KEY_BITS-1:0] s2;
    logic [KEY_BITS-1:0] cand;
    logic [CNT_W-1:0]    cnt;
    logic [KEY_BITS-1:0] kdata;
    logic                ready;
    logic                overrun;
    logic                ie;

    logic kdataRead;
    logic ctrlRead;
    logic ctrlWrite;
    logic keyEvent;

    // Exact full-width decode; no partial-address aliasing.
    assign kdataRead = re && (abus == ADDR_KDATA);
    assign ctrlRead  = re && (abus == ADDR_KCTRL);
    assign ctrlWrite = we && (abus == ADDR_KCTRL);

    // The candidate has been stable long enough and differs from what the
    // CPU currently sees.
    assign keyEvent = (cnt == CNT_MAX) && (cand != kdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            cand    <= '0;
            cnt     <= '0;
            kdata   <= '0;
            ready   <= 1'b0;
            overrun <= 1'b0;
            ie      <= 1'b0;
        end else begin
            // Invert on entry so the synchronizer resets to "nothing pressed".
            s1 <= ~KEY;
            s2 <= s1;

            // Any change restarts the stability count; otherwise count up
            // and saturate so a long-held value keeps qualifying.
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (keyEvent) begin
                kdata <= cand;
            end

            // A new event wins over a simultaneous read: the CPU read the old
            // value, so the new one is still pending.
            if (keyEvent) begin
                ready <= 1'b1;
            end else if (kdataRead) begin
                ready <= 1'b0;
            end

            // An unread value being replaced is an overrun; that outranks a
            // software clear on the same edge.
            if (keyEvent && ready && !kdataRead) begin
                overrun <= 1'b1;
            end else if (ctrlWrite && !dbusIn[1]) begin
                overrun <= 1'b0;
            end

            if (ctrlWrite) begin
                ie <= dbusIn[8];
            end
        end
    end

    always_comb begin
        dbusOut = '0;
        if (kdataRead) begin
            dbusOut = {{(DBITS-KEY_BITS){1'b0}}, kdata};
        end else if (ctrlRead) begin
            dbusOut[8] = ie;
            dbusOut[1] = overrun;
            dbusOut[0] = ready;
        end
    end

    assign intr = ready & ie;

    // Store-data bits with no register behind them.
    logic unusedDbus;
    assign unusedDbus = ^{dbusIn[DBITS-1:9], dbusIn[7:2], dbusIn[0]};

endmodule

// File: tb/tb_key_device.sv
// ---------------------------------------------------------------------------
// tb_key_device
//   Directed scenarios with a short debounce window, followed by a randomized
//   run compared cycle by cycle against a behavioural model. The model treats
//   debouncing as "the synchronized vector held the same value over a window
//   of DEBOUNCE_CYCLES samples" rather than tracking a counter.
// ---------------------------------------------------------------------------
module tb_key_device;

    localparam int          DBITS = 32;
    localparam int          KB    = 4;
    localparam int          D     = 4;
    localparam logic [31:0] AKD   = 32'hF0000010;
    localparam logic [31:0] AKC   = 32'hF0000110;
    localparam int          NRAND = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] abus;
    logic        we;
    logic        re;
    logic [31:0] dbusIn;
    logic [31:0] dbusOut;
    logic [3:0]  KEY;
    logic        intr;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] rv;

    key_device #(
        .DBITS(DBITS), .KEY_BITS(KB), .ADDR_KDATA(AKD), .ADDR_KCTRL(AKC),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .abus(abus), .we(we), .re(re),
        .dbusIn(dbusIn), .dbusOut(dbusOut), .KEY(KEY), .intr(intr)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observe a register without letting the strobe reach a clock edge.
    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        re = 1'b1; abus = addr;
        #1;
        data = dbusOut;
        re = 1'b0; abus = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; KEY = 4'hF; we = 1'b0; re = 1'b0; abus = '0; dbusIn = '0;
        #1;
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL reset_during_kctrl: got %h want %h", rv, 32'h0); end
        compared++;
        if (intr !== 1'b0) begin mismatched++; $display("FAIL reset_during_intr: got %b want 0", intr); end
        edges(3);
        reset = 1'b0;
        edges(20);
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL reset_kctrl: got %h want %h", rv, 32'h0); end
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL reset_kdata: got %h want %h", rv, 32'h0); end
        compared++;
        if (intr !== 1'b0) begin mismatched++; $display("FAIL reset_intr: got %b want 0", intr); end
        $display("test_reset: KEY=F held 20 cycles after reset");
    endtask

    task automatic test_press_latency();
        KEY = 4'hE;
        edges(6);
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL press_edge6_kdata: got %h want %h", rv, 32'h0); end
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL press_edge6_ready: got %h want %h", rv, 32'h0); end
        edges(1);
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h1) begin mismatched++; $display("FAIL press_edge7_kdata: got %h want %h", rv, 32'h1); end
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h1) begin mismatched++; $display("FAIL press_edge7_ready: got %h want %h", rv, 32'h1); end
        re = 1'b1; abus = AKD;
        edges(1);
        re = 1'b0; abus = '0;
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL press_read_clears: got %h want %h", rv, 32'h0); end
        // Release and consume the release event.
        KEY = 4'hF;
        edges(10);
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL release_kdata: got %h want %h", rv, 32'h0); end
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h1) begin mismatched++; $display("FAIL release_ready: got %h want %h", rv, 32'h1); end
        re = 1'b1; abus = AKD;
        edges(1);
        re = 1'b0; abus = '0;
        $display("test_press_latency: press E accepted on 7th edge, released");
    endtask

    task automatic test_glitch();
        KEY = 4'hE;
        edges(3);
        KEY = 4'hF;
        edges(12);
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL glitch_ready: got %h want %h", rv, 32'h0); end
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL glitch_kdata: got %h want %h", rv, 32'h0); end
        $display("test_glitch: 3-cycle pulse to E ignored");
    endtask

    task automatic test_overrun();
        KEY = 4'hE;
        edges(8);
        KEY = 4'hC;
        edges(8);
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h3) begin mismatched++; $display("FAIL overrun_kdata: got %h want %h", rv, 32'h3); end
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h3) begin mismatched++; $display("FAIL overrun_kctrl: got %h want %h", rv, 32'h3); end
        compared++;
        if (intr !== 1'b0) begin mismatched++; $display("FAIL overrun_intr_off: got %b want 0", intr); end
        we = 1'b1; abus = AKC; dbusIn = 32'h100;
        edges(1);
        we = 1'b0; abus = '0; dbusIn = '0;
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h101) begin mismatched++; $display("FAIL overrun_clear_kctrl: got %h want %h", rv, 32'h101); end
        compared++;
        if (intr !== 1'b1) begin mismatched++; $display("FAIL overrun_intr_on: got %b want 1", intr); end
        $display("test_overrun: two unread events, then KCTRL<=100");
    endtask

    task automatic test_same_edge_read();
        re = 1'b1; abus = AKD;
        edges(1);
        re = 1'b0; abus = '0;
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h100) begin mismatched++; $display("FAIL same_pre_kctrl: got %h want %h", rv, 32'h100); end
        KEY = 4'h8;
        edges(6);
        re = 1'b1; abus = AKD;
        #1;
        compared++;
        if (dbusOut !== 32'h3) begin mismatched++; $display("FAIL same_old_kdata: got %h want %h", dbusOut, 32'h3); end
        edges(1);
        re = 1'b0; abus = '0;
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h7) begin mismatched++; $display("FAIL same_new_kdata: got %h want %h", rv, 32'h7); end
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h101) begin mismatched++; $display("FAIL same_kctrl: got %h want %h", rv, 32'h101); end
        $display("test_same_edge_read: KDATA read coincides with event");
    endtask

    task automatic test_async_reset();
        compared++;
        if (intr !== 1'b1) begin mismatched++; $display("FAIL areset_intr_before: got %b want 1", intr); end
        KEY = 4'hF;
        edges(3);
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (intr !== 1'b0) begin mismatched++; $display("FAIL areset_intr_noedge: got %b want 0", intr); end
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL areset_kctrl_during: got %h want %h", rv, 32'h0); end
        edges(2);
        reset = 1'b0;
        readReg(AKD, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL areset_kdata_after: got %h want %h", rv, 32'h0); end
        edges(12);
        readReg(AKC, rv);
        compared++;
        if (rv !== 32'h0) begin mismatched++; $display("FAIL areset_kctrl_after: got %h want %h", rv, 32'h0); end
        $display("test_async_reset: reset mid-debounce with intr high");
    endtask

    task automatic test_random();
        logic [3:0]  hist [0:NRAND-1];
        logic [3:0]  mKdata;
        logic        mReady, mOv, mIe;
        logic [31:0] expOut;
        logic [3:0]  v, h;
        logic        stable, ev, rd, wr;
        int          holdLeft;
        int          op;

        mKdata = '0; mReady = 1'b0; mOv = 1'b0; mIe = 1'b0;
        holdLeft = 0;
        reset = 1'b1; re = 1'b0; we = 1'b0; abus = '0; dbusIn = '0; KEY = 4'hF;
        edges(2);
        reset = 1'b0;
        for (int n = 0; n < NRAND; n++) begin
            @(negedge clk);
            if (holdLeft == 0) begin
                KEY = 4'($urandom);
                holdLeft = $urandom_range(1, 9);
            end
            holdLeft--;
            op = $urandom_range(0, 9);
            re = (op <= 2) || (op == 5);
            we = (op == 3) || (op == 4) || (op == 5);
            case ($urandom_range(0, 4))
                0: abus = AKD;
                1: abus = AKC;
                2: abus = AKD ^ (32'h1 << $urandom_range(0, 31));
                3: abus = AKC;
                default: abus = $urandom;
            endcase
            dbusIn = $urandom;
            #1;
            expOut = '0;
            if (re && abus == AKD) expOut = {28'h0, mKdata};
            else if (re && abus == AKC) expOut = {23'h0, mIe, 6'h0, mOv, mReady};
            compared++;
            if (dbusOut !== expOut) begin mismatched++; $display("FAIL rand_dbus n=%0d: got %h want %h", n, dbusOut, expOut); end
            compared++;
            if (intr !== (mReady & mIe)) begin mismatched++; $display("FAIL rand_intr n=%0d: got %b want %b", n, intr, mReady & mIe); end
            if (re || we)
                $display("rand n=%0d re=%b we=%b abus=%h din=%h dout=%h KEY=%h", n, re, we, abus, dbusIn, dbusOut, KEY);

            @(posedge clk);
            hist[n] = ~KEY;
            // Accept a value once the synchronized vector has held it for D
            // consecutive samples (samples before reset count as released).
            v = (n >= 3) ? hist[n-3] : 4'h0;
            stable = 1'b1;
            for (int k = n - D - 2; k <= n - 3; k++) begin
                h = (k >= 0) ? hist[k] : 4'h0;
                if (h != v) stable = 1'b0;
            end
            ev = stable && (v != mKdata);
            rd = re && (abus == AKD);
            wr = we && (abus == AKC);
            if (ev && mReady && !rd) mOv = 1'b1;
            else if (wr && !dbusIn[1]) mOv = 1'b0;
            if (ev) mReady = 1'b1;
            else if (rd) mReady = 1'b0;
            if (wr) mIe = dbusIn[8];
            if (ev) mKdata = v;
        end
        @(negedge clk);
        re = 1'b0; we = 1'b0; abus = '0;
        $display("test_random: %0d cycles against model", NRAND);
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_overrun();
        test_same_edge_read();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
